// File: rtl/pc_update_unit.sv
// Program counter sequencer: BOOT/RUN/FLUSH/HALT control with branch, jump-register,
// stall and halt handling, plus a saturating count of issued fetches.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [31:0]      branch_offset,
    input  logic             jr_en,
    input  logic [31:0]      jr_addr,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_BOOT;
        else      r_state <= w_state_nxt;
    end

    // Halt outranks stall; redirects are only taken on an unstalled RUN cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALT;
                end else if (!stall) begin
                    if (jr_en) begin
                        w_pc_nxt    = {jr_addr[31:2], 2'b00};
                        w_state_nxt = S_FLUSH;
                    end else if (branch_en) begin
                        w_pc_nxt    = r_pc + branch_offset;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_pc_nxt    = r_pc + 32'd4;
                    end
                end
            end
            S_FLUSH: w_state_nxt = halt ? S_HALT : S_RUN;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (r_state == S_RUN);
        halted      = (r_state == S_HALT);
        w_issue     = (r_state == S_RUN) && !stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pc <= RESET_PC;
        else      r_pc <= w_pc_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_issue && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = r_pc + 32'd4;
    assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: vector table plus hand sequences, checked through a scoreboard queue.
module tb_pc_update_unit;

    logic        clk, rst, stall, branch_en, jr_en, halt;
    logic [31:0] branch_offset, jr_addr;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, halted;
    logic [15:0] issue_cnt;

    logic        z1;
    logic [31:0] z32;
    logic [31:0] pc2, pc2_plus4;
    logic        fv2, hd2;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    pc_update_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_offset(branch_offset), .jr_en(jr_en), .jr_addr(jr_addr), .halt(halt),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted),
        .issue_cnt(issue_cnt)
    );

    pc_update_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(z1), .branch_en(z1),
        .branch_offset(z32), .jr_en(z1), .jr_addr(z32), .halt(z1),
        .pc(pc2), .pc_plus4(pc2_plus4), .fetch_valid(fv2), .halted(hd2),
        .issue_cnt(cnt2)
    );

    typedef struct {
        logic        stall, br;
        logic [31:0] off;
        logic        jr;
        logic [31:0] jra;
        logic        hlt;
        logic [31:0] pc;
        logic        fv, hd;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        fv, hd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[18];

    logic [31:0] d2_pc[6];
    logic [1:0]  d2_cnt[6];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic s, b, input logic [31:0] o, input logic j,
                                input logic [31:0] ja, input logic h, input logic [31:0] p,
                                input logic fv, hd, input logic [15:0] c);
        vec_t v;
        v.stall = s; v.br = b; v.off = o; v.jr = j; v.jra = ja; v.hlt = h;
        v.pc = p; v.fv = fv; v.hd = hd; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        chk("halted", {31'd0, halted}, {31'd0, e.hd});
        chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, e.cnt});
    endtask

    task automatic push_exp(input logic [31:0] p, input logic fv, hd, input logic [15:0] c);
        exp_t e;
        e.pc = p; e.fv = fv; e.hd = hd; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic step(input vec_t v);
        stall = v.stall; branch_en = v.br; branch_offset = v.off;
        jr_en = v.jr; jr_addr = v.jra; halt = v.hlt;
        push_exp(v.pc, v.fv, v.hd, v.cnt);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic reset_pulse();
        rst = 0;
        #2;
        push_exp(32'h0, 1'b0, 1'b0, 16'd0);
        pop_compare();
        chk("dut2_reset_pc", pc2, 32'hFFFF_FFF8);
        rst = 1;
    endtask

    initial begin
        z1 = 0; z32 = '0;
        rst = 0; stall = 0; branch_en = 0; jr_en = 0; halt = 0;
        branch_offset = '0; jr_addr = '0;

        d2_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        d2_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        //            stall br  off           jr  jra           hlt  pc           fv hd cnt
        tbl[0]  = mk(0, 1, 32'h40,        0, 32'h0,        0, 32'h0,        1, 0, 0);
        tbl[1]  = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h4,        1, 0, 1);
        tbl[2]  = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h8,        1, 0, 2);
        tbl[3]  = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'hC,        1, 0, 3);
        tbl[4]  = mk(0, 0, 32'h0,         1, 32'h100,      0, 32'h100,      0, 0, 4);
        tbl[5]  = mk(0, 1, 32'h1000,      1, 32'h800,      0, 32'h100,      1, 0, 4);
        tbl[6]  = mk(0, 1, 32'hFFFF_FFF0, 0, 32'h0,        0, 32'hF0,       0, 0, 5);
        tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'hF0,       1, 0, 5);
        tbl[8]  = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'hF4,       1, 0, 6);
        tbl[9]  = mk(0, 1, 32'h10,        1, 32'h2003,     0, 32'h2000,     0, 0, 7);
        tbl[10] = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h2000,     1, 0, 7);
        tbl[11] = mk(1, 1, 32'h20,        0, 32'h0,        0, 32'h2000,     1, 0, 7);
        tbl[12] = mk(1, 1, 32'h20,        0, 32'h0,        0, 32'h2000,     1, 0, 7);
        tbl[13] = mk(1, 1, 32'h20,        0, 32'h0,        0, 32'h2000,     1, 0, 7);
        tbl[14] = mk(0, 1, 32'h20,        0, 32'h0,        0, 32'h2020,     0, 0, 8);
        tbl[15] = mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h2020,     1, 0, 8);
        tbl[16] = mk(1, 0, 32'h0,         1, 32'h3000,     0, 32'h2020,     1, 0, 8);
        tbl[17] = mk(1, 0, 32'h0,         1, 32'h4000,     1, 32'h2020,     0, 1, 8);

        repeat (2) @(posedge clk);
        #1;
        push_exp(32'h0, 1'b0, 1'b0, 16'd0);
        pop_compare();
        chk("dut2_reset_pc", pc2, 32'hFFFF_FFF8);
        rst = 1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i]);
            if (i < 6) begin
                chk("dut2_pc", pc2, d2_pc[i]);
                chk("dut2_cnt", {30'd0, cnt2}, {30'd0, d2_cnt[i]});
            end
        end

        // HALT must ignore every request for ten cycles.
        for (int k = 0; k < 10; k++) begin
            step(mk(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 1)), 32'h2020, 1'b0, 1'b1, 16'd8));
        end

        // Reset from HALT, then reset in the middle of a FLUSH.
        reset_pulse();
        step(mk(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0));
        step(mk(0, 0, 0, 1, 32'h500, 0, 32'h500, 0, 0, 1));
        reset_pulse();
        step(mk(0, 0, 0, 1, 32'h700, 0, 32'h0, 1, 0, 0));

        // Reset during a stalled branch discards it.
        step(mk(1, 1, 32'h80, 0, 0, 0, 32'h0, 1, 0, 0));
        reset_pulse();
        step(mk(0, 1, 32'h80, 0, 0, 0, 32'h0, 1, 0, 0));

        // Halt arriving during FLUSH.
        step(mk(0, 1, 32'h8, 0, 0, 0, 32'h8, 0, 0, 1));
        step(mk(0, 0, 0, 1, 32'h900, 1, 32'h8, 0, 1, 1));
        step(mk(0, 0, 0, 0, 0, 0, 32'h8, 0, 1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port stall, input, 1: hold PC and state this cycle.
REQ-006 SHALL have port branch_en, input, 1: taken PC-relative branch or jump this cycle.
REQ-007 SHALL have port branch_offset, input, 32: byte offset, already sign-extended from the 26-bit instruction field.
REQ-008 SHALL have port jr_en, input, 1: jump-register request this cycle.
REQ-009 SHALL have port jr_addr, input, 32: absolute target for jr_en.
REQ-010 SHALL have port halt, input, 1: halt request.
REQ-011 SHALL have port pc, output, 32: registered current PC (fetch address).
REQ-012 SHALL have port pc_plus4, output, 32: combinational pc + 4, modulo 2^32.
REQ-013 SHALL have port fetch_valid, output, 1: registered; pc holds a valid fetch address.
REQ-014 SHALL have port halted, output, 1: registered; unit is in HALT.
REQ-015 SHALL have port issue_cnt, output, CNT_W: registered count of issued fetches.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FLUSH, HALT.
REQ-017 BOOT SHALL last exactly one cycle after reset deassertion, with fetch_valid=0 and pc=RESET_PC, then go to RUN; inputs are ignored in BOOT.
REQ-018 In RUN, with no request and stall=0, pc SHALL become pc+4 on the next edge (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 In RUN with branch_en=1 and stall=0, pc SHALL become pc + branch_offset (32-bit two's-complement add, modulo 2^32) and the state SHALL go to FLUSH.
REQ-020 In RUN with jr_en=1 and stall=0, pc SHALL become {jr_addr[31:2],2'b00} and the state SHALL go to FLUSH.
REQ-021 Request priority in RUN SHALL be halt > jr_en > branch_en > sequential.
REQ-022 FLUSH SHALL last one cycle with fetch_valid=0 and pc held, then return to RUN; branch_en/jr_en in FLUSH SHALL be ignored; halt in FLUSH SHALL go to HALT.
REQ-023 halt=1 in RUN SHALL go to HALT with pc held, regardless of stall; halted=1 and fetch_valid=0 from the following cycle.
REQ-024 HALT SHALL be exited only by reset.
REQ-025 stall=1 in RUN SHALL hold pc, state and issue_cnt, and keep fetch_valid=1; branch/jr requests during stall SHALL be ignored (the requester holds them).
REQ-026 fetch_valid SHALL be 1 exactly when the state is RUN.
REQ-027 issue_cnt SHALL increment on each edge where the state is RUN and stall=0, and SHALL saturate at all ones.
REQ-028 Latency: a request sampled at edge N SHALL appear on pc after edge N; the redirected pc SHALL be valid again after edge N+1.

Reset
REQ-029 On rst=0, asynchronously: pc=RESET_PC, state=BOOT, fetch_valid=0, halted=0, issue_cnt=0.
REQ-030 Reset asserted mid-FLUSH or mid-stall SHALL discard the pending redirect and give the REQ-029 values.

Verification
REQ-031 Reset release, no requests, 4 cycles -> pc 0,0,4,8,12; fetch_valid 0,1,1,1; issue_cnt 0 then increments from the first RUN edge.
REQ-032 pc=0x100, branch_en=1, branch_offset=0xFFFF_FFF0 -> pc=0x0F0, one fetch_valid=0 cycle, then 0x0F4.
REQ-033 branch_en=1 and jr_en=1 with jr_addr=0x2003 in the same cycle -> pc=0x2000 (jr wins), FLUSH once.
REQ-034 stall=1 for 3 cycles with branch_en=1 -> pc and issue_cnt unchanged; branch taken on the first edge with stall=0.
REQ-035 pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000; CNT_W=2 with 5 issues -> issue_cnt saturates at 3.
REQ-036 halt=1 with stall=1 -> halted=1 next cycle, pc frozen for 10 cycles; rst low pulse -> BOOT, pc=RESET_PC.
